multiplexor_nx1_reg: RTL and testbench

MULTIPLEXOR_NX1_REG -- requirements
Module: multiplexor_nx1_reg

---
 rtl/multiplexor_nx1_reg.sv | 127 ++++++++++++
 tb/tb_multiplexor_nx1_reg.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplexor_nx1_reg.sv
// multiplexor_nx1_reg: N-to-1 multiplexor with a registered one-entry output stage.
// A capture (IN_VALID && IN_READY) loads the selected channel into Y/CH with
// one cycle of latency. The output stage is a two-state FSM (EMPTY/FULL) whose
// state is visible on Y_VALID.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// The upstream side is IN_VALID/IN_READY and the downstream side is Y_VALID/Y_READY.
// IN_READY is combinational: the block accepts new data when the output
// register is empty or is being drained in the same cycle.
//
// Optional feature: define MUX_SCAN_EN to build the auto-scan counter. When SCAN=1,
// the counter selects the channel and advances on each capture. Without the macro,
// the SCAN input is accepted but ignored, and S always selects the channel.
module multiplexor_nx1_reg #(
  parameter int W = 4,
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  D,
  input  logic [SW-1:0]   S,
  input  logic            E,
  input  logic            SCAN,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic [W-1:0]    Y,
  output logic [SW-1:0]   CH,
  output logic            Y_VALID,
  input  logic            Y_READY
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_y;
  logic [W-1:0]   w_y_nxt;
  logic [SW-1:0]  r_ch;
  logic [SW-1:0]  w_ch_nxt;
  logic [SW-1:0]  w_idx;
  logic [W-1:0]   w_sel_data;
  logic           w_in_ready;
  logic           w_capture;

`ifdef MUX_SCAN_EN
  logic [SW-1:0]  r_scan_cnt;
  logic [SW-1:0]  w_scan_cnt_nxt;

  // Scan mode selects the channel from the counter; direct mode uses S.
  assign w_idx = SCAN ? r_scan_cnt : S;
`else
  logic           w_unused_scan;

  assign w_unused_scan = SCAN;
  assign w_idx         = S;
`endif

  // Accept a capture when enabled, not in reset, and the output slot is free or draining.
  assign w_in_ready = !reset && !E && ((r_state == ST_EMPTY) || Y_READY);
  assign w_capture  = IN_VALID && w_in_ready;

  // Channel select; an index with no matching channel (>= N) yields zero data.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (w_idx == SW'(k)) begin
        w_sel_data = D[k*W +: W];
      end
    end
  end

  // Next-state logic for the output stage and scan counter; disable beats capture.
  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_ch_nxt    = r_ch;
`ifdef MUX_SCAN_EN
    w_scan_cnt_nxt = r_scan_cnt;
`endif
    if (E) begin
      w_state_nxt = ST_EMPTY;
      w_y_nxt     = '0;
      w_ch_nxt    = '0;
    end else if (w_capture) begin
      w_state_nxt = ST_FULL;
      w_y_nxt     = w_sel_data;
      w_ch_nxt    = w_idx;
`ifdef MUX_SCAN_EN
      if (SCAN) begin
        w_scan_cnt_nxt = (r_scan_cnt == SW'(N - 1)) ? '0 : r_scan_cnt + SW'(1);
      end
`endif
    end else if ((r_state == ST_FULL) && Y_READY) begin
      // Drained with nothing new: Y/CH keep their last values.
      w_state_nxt = ST_EMPTY;
    end
  end

  // State and data registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_y     <= '0;
      r_ch    <= '0;
`ifdef MUX_SCAN_EN
      r_scan_cnt <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_ch    <= w_ch_nxt;
`ifdef MUX_SCAN_EN
      r_scan_cnt <= w_scan_cnt_nxt;
`endif
    end
  end

  assign IN_READY = w_in_ready;
  assign Y        = r_y;
  assign CH       = r_ch;
  assign Y_VALID  = (r_state == ST_FULL);

endmodule

// File: tb/tb_multiplexor_nx1_reg.sv
// Bench for multiplexor_nx1_reg: two instances (N=4 and N=3, W=4) share stimulus.
// A behavioural model predicts every output on every cycle, and directed
// literal checks pin the model against hand-computed values.
module tb_multiplexor_nx1_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] D;
  logic [1:0]  S;
  logic        E;
  logic        SCAN;
  logic        IN_VALID;
  logic        Y_READY;

  logic        ir4, yv4, ir3, yv3;
  logic [3:0]  y4, y3;
  logic [1:0]  ch4, ch3;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

`ifdef MUX_SCAN_EN
  localparam bit SCAN_BUILT = 1'b1;
`else
  localparam bit SCAN_BUILT = 1'b0;
`endif

  multiplexor_nx1_reg #(.W(4), .N(4)) dut4 (
    .clk(clk), .reset(reset), .D(D), .S(S), .E(E), .SCAN(SCAN),
    .IN_VALID(IN_VALID), .IN_READY(ir4), .Y(y4), .CH(ch4),
    .Y_VALID(yv4), .Y_READY(Y_READY)
  );

  multiplexor_nx1_reg #(.W(4), .N(3)) dut3 (
    .clk(clk), .reset(reset), .D(D[11:0]), .S(S), .E(E), .SCAN(SCAN),
    .IN_VALID(IN_VALID), .IN_READY(ir3), .Y(y3), .CH(ch3),
    .Y_VALID(yv3), .Y_READY(Y_READY)
  );

  // ---------------- behavioural model ----------------
  // Index 0 models the N=4 instance, index 1 models the N=3 instance.
  int m_valid [2];
  int m_y     [2];
  int m_ch    [2];
  int m_cnt   [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_y[i] = 0; m_ch[i] = 0; m_cnt[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int n;
      int idx;
      bit rdy;
      bit use_scan;
      n = (i == 0) ? 4 : 3;
      use_scan = SCAN_BUILT && SCAN;
      if (reset) begin
        m_valid[i] = 0; m_y[i] = 0; m_ch[i] = 0; m_cnt[i] = 0;
      end else if (E) begin
        m_valid[i] = 0; m_y[i] = 0; m_ch[i] = 0;
      end else begin
        rdy = (m_valid[i] == 0) || Y_READY;
        if (IN_VALID && rdy) begin
          idx = use_scan ? m_cnt[i] : int'(S);
          m_y[i]     = (idx < n) ? int'((D >> (idx * 4)) & 16'hF) : 0;
          m_ch[i]    = idx;
          m_valid[i] = 1;
          if (use_scan) m_cnt[i] = (m_cnt[i] + 1) % n;
        end else if (m_valid[i] != 0 && Y_READY) begin
          m_valid[i] = 0;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_ready(input int i);
    return (!reset && !E && (m_valid[i] == 0 || Y_READY)) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m4_y",   int'(y4),  m_y[0]);
      check("m4_ch",  int'(ch4), m_ch[0]);
      check("m4_yv",  int'(yv4), m_valid[0]);
      check("m4_ir",  int'(ir4), exp_ready(0));
      check("m3_y",   int'(y3),  m_y[1]);
      check("m3_ch",  int'(ch3), m_ch[1]);
      check("m3_yv",  int'(yv3), m_valid[1]);
      check("m3_ir",  int'(ir3), exp_ready(1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic yr, input logic [1:0] s,
                       input logic e, input logic sc);
    IN_VALID = iv; Y_READY = yr; S = s; E = e; SCAN = sc;
  endtask

  // Directed vector table: {E, IN_VALID, Y_READY, S, D}
  localparam int NV = 10;
  logic [20:0] tv [NV] = '{
    {1'b0, 1'b1, 1'b0, 2'd3, 16'h9E71},
    {1'b0, 1'b1, 1'b0, 2'd1, 16'h9E71},
    {1'b0, 1'b0, 1'b1, 2'd0, 16'h0000},
    {1'b0, 1'b1, 1'b1, 2'd2, 16'h6B2F},
    {1'b0, 1'b1, 1'b1, 2'd0, 16'h6B2F},
    {1'b1, 1'b1, 1'b1, 2'd3, 16'hFFFF},
    {1'b0, 1'b1, 1'b1, 2'd3, 16'h8D04},
    {1'b0, 1'b0, 1'b0, 2'd1, 16'h1111},
    {1'b0, 1'b1, 1'b1, 2'd1, 16'h2C5A},
    {1'b0, 1'b0, 1'b1, 2'd2, 16'h0000}
  };

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; D = '0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    cmp_en = 1'b1;
    check("rst_in_ready", int'(ir4), 0);
    tick();
    check("rst_y",  int'(y4),  0);
    check("rst_ch", int'(ch4), 0);
    check("rst_yv", int'(yv4), 0);
    reset = 1'b0;

    // Direct capture of channel 2 from 16'hA5C3 -> 5.
    D = 16'hA5C3;
    drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    check("dir_y",  int'(y4),  5);
    check("dir_ch", int'(ch4), 2);
    check("dir_yv", int'(yv4), 1);

    // Capture 3, then stall downstream for 3 cycles.
    drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    tick();
    check("cap3_y", int'(y4), 3);
    drive(1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_ir", int'(ir4), 0);
      check("stall_y",  int'(y4),  3);
      check("stall_yv", int'(yv4), 1);
      tick();
    end
    // Release: new capture with no empty cycle.
    drive(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    #1;
    check("release_ir", int'(ir4), 1);
    tick();
    check("b2b_y",  int'(y4),  12);
    check("b2b_ch", int'(ch4), 1);
    check("b2b_yv", int'(yv4), 1);

    // Disable while FULL holding 4'hC.
    drive(1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
    #1;
    check("dis_ir", int'(ir4), 0);
    tick();
    check("dis_y",  int'(y4),  0);
    check("dis_ch", int'(ch4), 0);
    check("dis_yv", int'(yv4), 0);

    // S=3: N=4 gets 4'hA; N=3 gets out-of-range zero with CH=3.
    drive(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    tick();
    check("s3_n4_y",  int'(y4),  10);
    check("s3_n3_y",  int'(y3),  0);
    check("s3_n3_ch", int'(ch3), 3);
    check("s3_n3_yv", int'(yv3), 1);
    // Drain without new capture: empty, data held.
    drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    tick();
    check("drain_yv", int'(yv4), 0);
    check("drain_y",  int'(y4),  10);
    check("drain_ch", int'(ch4), 3);

    // Reset mid-transfer while FULL with IN_VALID high.
    drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check("midrst_y",  int'(y4),  0);
    check("midrst_yv", int'(yv4), 0);
    reset = 1'b0;

    // Directed vector table, checked by the model every cycle.
    for (int v = 0; v < NV; v++) begin
      D = tv[v][15:0];
      drive(tv[v][19], tv[v][18], tv[v][17:16], tv[v][20], 1'b0);
      tick();
    end

`ifdef MUX_SCAN_EN
    // Auto-scan: CH 0,1,2,3,0,1 (N=4) and 0,1,2,0,1,2 (N=3).
    reset = 1'b1; drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0); tick(); reset = 1'b0;
    D = 16'h4321;
    drive(1'b1, 1'b1, 2'd3, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("scan_n4_ch", int'(ch4), c % 4);
      check("scan_n4_y",  int'(y4),  (c % 4) + 1);
      check("scan_n3_ch", int'(ch3), c % 3);
    end
    // Direct capture in between must not disturb the counter.
    drive(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    tick();
    check("scan_dir_ch", int'(ch4), 3);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
    tick();
    check("scan_resume_n4", int'(ch4), 2);
    check("scan_resume_n3", int'(ch3), 0);
    // Reset restarts the counter.
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("scan_rst_yv", int'(yv4), 0);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
    tick();
    check("scan_rst_ch", int'(ch4), 0);
`else
    // SCAN is ignored when the counter is not built.
    drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
    D = 16'h4321;
    tick();
    check("noscan_ch", int'(ch4), 2);
    check("noscan_y",  int'(y4),  3);
    tick();
    check("noscan_ch2", int'(ch4), 2);
`endif

    drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
